pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
- 16-bit program counter register with its incrementor built in, plus a valid/ready address handshake toward instruction memory.
- Sits between the CPU control path (jump/load, reset, advance) and the instruction ROM address port.
- Owns the PC register, its next-PC selection, and the one-cycle fetch bubbles after boot and after jumps.

Parameters:
- WIDTH, 16, PC and address width.
- RESET_VECTOR, 16'h0000, PC value after rst_n and after clr.
- BUBBLE_ON_LOAD, 1, 1 = insert one fetch_valid=0 cycle after each load; 0 = no bubble.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous CPU reset request; forces PC to RESET_VECTOR.
- load  in  1  jump taken; PC takes load_addr.
- load_addr  in  WIDTH  jump target.
- inc  in  1  advance enable; PC increments on an accepted fetch.
- fetch_ready  in  1  instruction memory accepts the presented address.
- fetch_valid  out  1  pc is a valid fetch address this cycle.
- pc  out  WIDTH  current PC (registered).
- pc_next  out  WIDTH  combinational pc+1, modulo 2^WIDTH.
- wrap  out  1  registered one-cycle pulse after a PC increment from all-ones to zero.
- state  out  2  FSM state (debug): BOOT=2'b00, RUN=2'b01, BUBBLE=2'b10.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- rst_n=0 immediately sets:
  - state=BOOT, pc=RESET_VECTOR, wrap=0.
  - fetch_valid=0, which is decoded from state as fetch_valid = (state==RUN).
- accept = fetch_valid & fetch_ready.
- Priority in every state: clr > load > increment > hold.
- BOOT:
  - clr: stay BOOT, pc=RESET_VECTOR.
  - load: pc<=load_addr; next state BUBBLE if BUBBLE_ON_LOAD=1, else RUN.
  - Otherwise: next state RUN, pc held; inc ignored.
- RUN:
  - clr: pc<=RESET_VECTOR, next state BOOT.
  - load: pc<=load_addr regardless of fetch_ready. An unaccepted fetch is dropped. Next state BUBBLE if BUBBLE_ON_LOAD=1, else RUN.
  - inc & accept: pc<=pc_next, stay RUN.
  - accept with inc=0: pc held; the same address is re-presented next cycle.
  - fetch_ready=0: pc and fetch_valid stay stable; no address change while valid and not ready, except via clr or load.
- BUBBLE:
  - clr: pc<=RESET_VECTOR, next state BOOT.
  - load: pc<=load_addr, stay BUBBLE (back-to-back jumps each cost one bubble).
  - Otherwise: next state RUN; inc ignored.
- Arithmetic:
  - pc_next = pc + 1, truncated to WIDTH bits; 16'hFFFF -> 16'h0000.
  - No carry out; wrap reports the event instead.
- wrap:
  - Set to 1 for exactly the cycle after an increment where pc was all-ones.
  - Otherwise 0, including when a load writes 0.
- Latency:
  - load/clr visible on pc one cycle after the sampling edge.
  - First valid fetch after rst_n release occurs on the 2nd clock edge.
- Unused state encoding 2'b11 recovers to BOOT with pc=RESET_VECTOR.
- rst_n asserted mid-stall or mid-bubble aborts everything immediately; no pending load survives.

Test Plan:
- Reset/boot: rst_n low then released, inc=1, fetch_ready=1 -> cycle 1 state=BOOT, fetch_valid=0, pc=0; cycle 2 fetch_valid=1, pc=0; then pc=1,2,3 on successive cycles.
- Stall: in RUN at pc=5, fetch_ready=0 for 3 cycles -> pc stays 5, fetch_valid=1; ready returns -> pc=6 next cycle.
- Jump with bubble: pc=7, load=1, load_addr=16'h0100 -> pc=0x0100, fetch_valid=0 for one cycle, then valid at 0x0100, then 0x0101. With BUBBLE_ON_LOAD=0 -> no invalid cycle.
- Priority: clr=1, load=1, load_addr=0x0055 in RUN at pc=0x0020 -> pc=0x0000, state=BOOT. Then load alone at pc=9 with fetch_ready=0 -> pc=0x0055.
- Wrap: load 16'hFFFF, then accepted inc -> pc=0x0000, wrap=1 for exactly one cycle. Separately, load 0x0000 -> wrap stays 0.
- Async reset mid-bubble: assert rst_n=0 between edges while in BUBBLE at pc=0x0100 -> pc=0, fetch_valid=0, state=BOOT immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - program counter with next-PC select and fetch address handshake
module pc_fetch_ctrl #(
  parameter int unsigned         WIDTH          = 16,
  parameter logic [WIDTH-1:0]    RESET_VECTOR   = '0,
  parameter bit                  BUBBLE_ON_LOAD = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_addr,
  input  logic             inc,
  input  logic             fetch_ready,
  output logic             fetch_valid,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_next,
  output logic             wrap,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    ST_BOOT   = 2'b00,
    ST_RUN    = 2'b01,
    ST_BUBBLE = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             wrap_q, wrap_d;
  logic             accept;

  // Post-jump target state: a bubble gives the ROM one cycle to settle on the new address.
  localparam state_e LOAD_STATE = BUBBLE_ON_LOAD ? ST_BUBBLE : ST_RUN;

  assign pc_next = pc_q + WIDTH'(1);
  assign accept  = fetch_valid & fetch_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_VECTOR;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wrap_q  <= wrap_d;
    end
  end

  always_comb begin
    state_d = ST_BOOT;
    pc_d    = pc_q;
    wrap_d  = 1'b0;
    case (state_q)
      ST_BOOT: begin
        if (clr) begin
          state_d = ST_BOOT;
          pc_d    = RESET_VECTOR;
        end else if (load) begin
          state_d = LOAD_STATE;
          pc_d    = load_addr;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (clr) begin
          state_d = ST_BOOT;
          pc_d    = RESET_VECTOR;
        end else if (load) begin
          state_d = LOAD_STATE;
          pc_d    = load_addr;
        end else begin
          state_d = ST_RUN;
          if (inc && accept) begin
            pc_d   = pc_next;
            wrap_d = &pc_q;
          end
        end
      end
      ST_BUBBLE: begin
        if (clr) begin
          state_d = ST_BOOT;
          pc_d    = RESET_VECTOR;
        end else if (load) begin
          state_d = ST_BUBBLE;
          pc_d    = load_addr;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_BOOT;
        pc_d    = RESET_VECTOR;
      end
    endcase
  end

  always_comb begin
    fetch_valid = (state_q == ST_RUN);
    pc          = pc_q;
    wrap        = wrap_q;
    state       = state_q;
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb/tb_pc_fetch_ctrl.sv - table-driven directed bench for pc_fetch_ctrl
module tb_pc_fetch_ctrl;

  localparam logic [1:0] S_BOOT = 2'b00, S_RUN = 2'b01, S_BUB = 2'b10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 0, load = 0, inc = 0, fetch_ready = 0;
  logic [15:0] load_addr = '0;
  logic        fetch_valid, wrap;
  logic [15:0] pc, pc_next;
  logic [1:0]  state;

  logic        b_clr = 0, b_load = 0, b_inc = 0, b_ready = 0;
  logic [15:0] b_load_addr = '0;
  logic        b_valid, b_wrap;
  logic [15:0] b_pc, b_pc_next;
  logic [1:0]  b_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_fetch_ctrl #(.WIDTH(16), .RESET_VECTOR(16'h0000), .BUBBLE_ON_LOAD(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_addr(load_addr),
    .inc(inc), .fetch_ready(fetch_ready), .fetch_valid(fetch_valid), .pc(pc),
    .pc_next(pc_next), .wrap(wrap), .state(state)
  );

  pc_fetch_ctrl #(.WIDTH(16), .RESET_VECTOR(16'h0000), .BUBBLE_ON_LOAD(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .clr(b_clr), .load(b_load), .load_addr(b_load_addr),
    .inc(b_inc), .fetch_ready(b_ready), .fetch_valid(b_valid), .pc(b_pc),
    .pc_next(b_pc_next), .wrap(b_wrap), .state(b_state)
  );

  typedef struct {
    logic        clr;
    logic        load;
    logic [15:0] addr;
    logic        inc;
    logic        rdy;
    logic [15:0] exp_pc;
    logic [1:0]  exp_state;
    logic        exp_wrap;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic c, input logic l, input logic [15:0] a, input logic i,
                     input logic r, input logic [15:0] epc, input logic [1:0] est,
                     input logic ew);
    vec_t v;
    v.clr = c; v.load = l; v.addr = a; v.inc = i; v.rdy = r;
    v.exp_pc = epc; v.exp_state = est; v.exp_wrap = ew;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_main(input string tag, input logic [15:0] epc, input logic [1:0] est,
                            input logic ew);
    logic [15:0] nxt;
    nxt = epc + 16'd1;
    check({tag, " pc"}, pc, epc);
    check({tag, " state"}, 16'(state), 16'(est));
    check({tag, " valid"}, 16'(fetch_valid), 16'(est == S_RUN));
    check({tag, " wrap"}, 16'(wrap), 16'(ew));
    check({tag, " pc_next"}, pc_next, nxt);
  endtask

  initial begin
    // boot and sequential fetch
    add(0,0,16'h0000,1,1, 16'h0000,S_RUN,0);
    add(0,0,16'h0000,1,1, 16'h0001,S_RUN,0);
    add(0,0,16'h0000,1,1, 16'h0002,S_RUN,0);
    add(0,0,16'h0000,1,1, 16'h0003,S_RUN,0);
    add(0,0,16'h0000,1,1, 16'h0004,S_RUN,0);
    add(0,0,16'h0000,1,1, 16'h0005,S_RUN,0);
    // stall at 5
    add(0,0,16'h0000,1,0, 16'h0005,S_RUN,0);
    add(0,0,16'h0000,1,0, 16'h0005,S_RUN,0);
    add(0,0,16'h0000,1,0, 16'h0005,S_RUN,0);
    add(0,0,16'h0000,1,1, 16'h0006,S_RUN,0);
    add(0,0,16'h0000,1,1, 16'h0007,S_RUN,0);
    // jump with bubble from 7
    add(0,1,16'h0100,1,1, 16'h0100,S_BUB,0);
    add(0,0,16'h0000,1,1, 16'h0100,S_RUN,0);
    add(0,0,16'h0000,1,1, 16'h0101,S_RUN,0);
    // priority: clr beats load
    add(0,1,16'h0020,0,1, 16'h0020,S_BUB,0);
    add(0,0,16'h0000,1,1, 16'h0020,S_RUN,0);
    add(1,1,16'h0055,1,1, 16'h0000,S_BOOT,0);
    add(0,0,16'h0000,0,1, 16'h0000,S_RUN,0);
    add(0,1,16'h0009,0,1, 16'h0009,S_BUB,0);
    add(0,0,16'h0000,0,1, 16'h0009,S_RUN,0);
    add(0,1,16'h0055,1,0, 16'h0055,S_BUB,0);
    add(0,0,16'h0000,0,1, 16'h0055,S_RUN,0);
    add(0,0,16'h0000,0,1, 16'h0055,S_RUN,0);
    // wrap
    add(0,1,16'hFFFF,0,1, 16'hFFFF,S_BUB,0);
    add(0,0,16'h0000,0,1, 16'hFFFF,S_RUN,0);
    add(0,0,16'h0000,1,1, 16'h0000,S_RUN,1);
    add(0,0,16'h0000,1,1, 16'h0001,S_RUN,0);
    add(0,1,16'h0000,1,1, 16'h0000,S_BUB,0);
    add(0,0,16'h0000,0,1, 16'h0000,S_RUN,0);
    // back-to-back loads, clr from bubble, BOOT behaviour
    add(0,1,16'h0200,1,1, 16'h0200,S_BUB,0);
    add(0,1,16'h0300,1,1, 16'h0300,S_BUB,0);
    add(0,0,16'h0000,1,1, 16'h0300,S_RUN,0);
    add(0,1,16'h0100,1,1, 16'h0100,S_BUB,0);
    add(1,0,16'h0000,1,1, 16'h0000,S_BOOT,0);
    add(1,0,16'h0000,1,1, 16'h0000,S_BOOT,0);
    add(0,0,16'h0000,1,1, 16'h0000,S_RUN,0);
    add(0,1,16'h0040,1,1, 16'h0040,S_BUB,0);
    add(0,1,16'h0100,0,1, 16'h0100,S_BUB,0);

    #12;
    check_main("reset", 16'h0000, S_BOOT, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    inc = 1'b1;
    fetch_ready = 1'b1;
    #1;
    check_main("boot cycle1", 16'h0000, S_BOOT, 1'b0);

    for (int k = 0; k < vecs.size(); k++) begin
      if (k != 0) @(negedge clk);
      clr = vecs[k].clr; load = vecs[k].load; load_addr = vecs[k].addr;
      inc = vecs[k].inc; fetch_ready = vecs[k].rdy;
      @(posedge clk);
      #1;
      check_main($sformatf("vec%0d", k), vecs[k].exp_pc, vecs[k].exp_state, vecs[k].exp_wrap);
    end

    // async reset mid-bubble with a load still pending on the inputs
    #2;
    rst_n = 1'b0;
    #1;
    check_main("async reset", 16'h0000, S_BOOT, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check_main("reset held", 16'h0000, S_BOOT, 1'b0);
    clr = 0; load = 0; inc = 0;
    rst_n = 1'b1;

    // no-bubble variant
    @(posedge clk); #1;
    check("nb boot pc", b_pc, 16'h0000);
    check("nb boot state", 16'(b_state), 16'(S_RUN));
    @(negedge clk);
    b_load = 1'b1; b_load_addr = 16'h0100; b_inc = 1'b1; b_ready = 1'b1;
    @(posedge clk); #1;
    check("nb load pc", b_pc, 16'h0100);
    check("nb load valid", 16'(b_valid), 16'd1);
    check("nb load state", 16'(b_state), 16'(S_RUN));
    @(negedge clk);
    b_load = 1'b0;
    @(posedge clk); #1;
    check("nb inc pc", b_pc, 16'h0101);
    check("nb inc valid", 16'(b_valid), 16'd1);
    check("nb pc_next", b_pc_next, 16'h0102);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
